// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller at the MEM/WB boundary: picks the winning
// exception, strobes the CP0 update port once, then flushes and redirects the pipeline.
module exc_commit_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallW,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [31:0] mem_addr,
    input  logic        exc_adel_if,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic        exc_sys,
    input  logic        exc_bp,
    input  logic        exc_adel_d,
    input  logic        exc_ades,
    input  logic        is_eret,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_mtc0_we,
    input  logic [4:0]  wb_mtc0_addr,
    input  logic [31:0] wb_mtc0_data,
    output logic        cp0_en,
    output logic [31:0] except_type,
    output logic [31:0] exc_pc,
    output logic        exc_bd,
    output logic [31:0] badvaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000e;
    localparam logic [4:0]  CP0_REG_EPC   = 5'd14;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cp0_en_q, flush_q, redirect_valid_q, busy_q;
    logic [31:0] except_type_q, exc_pc_q, badvaddr_q, redirect_pc_q;
    logic        exc_bd_q;

    logic        int_pending_s;
    logic        req_s;
    logic [31:0] type_s;
    logic [31:0] badvaddr_s;
    logic [31:0] target_s;

    assign int_pending_s = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

    // Priority select of the committed exception, its BadVAddr and redirect target
    always_comb begin
        type_s     = 32'h0000_0000;
        badvaddr_s = 32'h0000_0000;
        target_s   = EXC_VECTOR;
        if (int_pending_s) begin
            type_s = EXC_TYPE_INT;
        end else if (exc_adel_if) begin
            type_s     = EXC_TYPE_ADEL;
            badvaddr_s = mem_pc;
        end else if (exc_ri) begin
            type_s = EXC_TYPE_RI;
        end else if (exc_ov) begin
            type_s = EXC_TYPE_OV;
        end else if (exc_sys) begin
            type_s = EXC_TYPE_SYS;
        end else if (exc_bp) begin
            type_s = EXC_TYPE_BP;
        end else if (exc_adel_d) begin
            type_s     = EXC_TYPE_ADEL;
            badvaddr_s = mem_addr;
        end else if (exc_ades) begin
            type_s     = EXC_TYPE_ADES;
            badvaddr_s = mem_addr;
        end else if (is_eret) begin
            type_s = EXC_TYPE_ERET;
            // An mtc0 to EPC in WB this cycle has not reached epc_i yet
            if (wb_mtc0_we && (wb_mtc0_addr == CP0_REG_EPC)) begin
                target_s = wb_mtc0_data;
            end else begin
                target_s = epc_i;
            end
        end else begin
            type_s = 32'h0000_0000;
        end
    end

    assign req_s = (state_q == ST_IDLE) & mem_valid & ~stallW &
                   (int_pending_s | exc_adel_if | exc_ri | exc_ov | exc_sys |
                    exc_bp | exc_adel_d | exc_ades | is_eret);

    // Sequencer next state and flush counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = FLUSH_LOAD;
                state_d = MULTI_FLUSH ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_FLUSH;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and registered control strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 4'd0;
            cp0_en_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cp0_en_q         <= (state_d == ST_ISSUE);
            redirect_valid_q <= (state_d == ST_ISSUE);
            flush_q          <= (state_d != ST_IDLE);
            busy_q           <= (state_d != ST_IDLE);
        end
    end

    // Commit payload, captured only when a request is accepted and held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            except_type_q <= 32'h0000_0000;
            exc_pc_q      <= 32'h0000_0000;
            exc_bd_q      <= 1'b0;
            badvaddr_q    <= 32'h0000_0000;
            redirect_pc_q <= 32'h0000_0000;
        end else if (req_s) begin
            except_type_q <= type_s;
            exc_pc_q      <= mem_pc;
            exc_bd_q      <= mem_in_delayslot;
            badvaddr_q    <= badvaddr_s;
            redirect_pc_q <= target_s;
        end else begin
            except_type_q <= except_type_q;
            exc_pc_q      <= exc_pc_q;
            exc_bd_q      <= exc_bd_q;
            badvaddr_q    <= badvaddr_q;
            redirect_pc_q <= redirect_pc_q;
        end
    end

    assign cp0_en         = cp0_en_q;
    assign redirect_valid = redirect_valid_q;
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign except_type    = except_type_q;
    assign exc_pc         = exc_pc_q;
    assign exc_bd         = exc_bd_q;
    assign badvaddr       = badvaddr_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Exception/interrupt commit controller in the MEM/WB boundary; sequences the CP0 register file's exception-update port.
- Prioritises the per-instruction exception flags and pending interrupts, then issues a one-cycle CP0 update strobe with type, PC, BD flag and BadVAddr.
- Drives pipeline flush and PC redirect: to the exception vector, or to EPC for ERET, with EPC forwarded from an in-flight mtc0.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions and interrupts.
- FLUSH_CYCLES, 2, total cycles flush stays high per commit (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stallW  in  1  WB stall; no new commit is accepted while high.
- mem_valid  in  1  MEM holds a real instruction.
- mem_pc  in  32  PC of the MEM instruction.
- mem_in_delayslot  in  1  MEM instruction is in a delay slot.
- mem_addr  in  32  load/store effective address.
- exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades, is_eret  in  1 each  exception flags of the MEM instruction.
- status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC.
- wb_mtc0_we  in  1  mtc0 write in flight this cycle.
- wb_mtc0_addr  in  5  its CP0 register number.
- wb_mtc0_data  in  32  its data.
- cp0_en  out  1  one-cycle CP0 exception-update strobe.
- except_type  out  32  defines.vh EXC_TYPE_* code.
- exc_pc  out  32  instruction PC for the CP0 update.
- exc_bd  out  1  delay-slot flag for the CP0 update.
- badvaddr  out  32  faulting virtual address.
- flush  out  1  squash IF..MEM.
- redirect_valid  out  1  one-cycle PC redirect.
- redirect_pc  out  32  redirect target.
- busy  out  1  commit sequence in progress.

Behaviour:
- Reset (async): state IDLE; every output 0; flush counter 0.
- int_pending = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- Request in cycle T = state IDLE & mem_valid & ~stallW & (int_pending | any exception flag | is_eret).
- Priority, highest first: INT, ADEL (exc_adel_if), RI, OV, SYS, BP, ADEL (exc_adel_d), ADES, ERET.
- badvaddr source:
  - exc_adel_if wins: mem_pc.
  - exc_adel_d or exc_ades wins: mem_addr.
  - Otherwise: 0.
- ERET target:
  - wb_mtc0_we & wb_mtc0_addr==`CP0_REG_EPC in T: wb_mtc0_data (forwarded).
  - Otherwise: epc_i.
- Non-ERET target: EXC_VECTOR.
- At the edge ending T, register except_type, exc_pc=mem_pc, exc_bd=mem_in_delayslot, badvaddr and redirect_pc; go to ISSUE.
- ISSUE, 1 cycle (T+1):
  - cp0_en=1, redirect_valid=1, flush=1, busy=1.
  - Flush counter loads FLUSH_CYCLES-1.
  - Next state FLUSH if FLUSH_CYCLES>1, else IDLE.
- FLUSH:
  - flush=1, busy=1, cp0_en=0, redirect_valid=0; counter decrements each cycle.
  - Goes to IDLE on the cycle the counter reaches 1.
- IDLE: cp0_en, redirect_valid, flush and busy are 0. except_type, exc_pc, exc_bd, badvaddr and redirect_pc hold their last values.
- Requests are ignored while busy; flushed instructions produce no further commit.
- stallW high during ISSUE or FLUSH does not extend or delay the sequence.
- stallW high in IDLE blocks acceptance; the request is taken on the first cycle stallW is low.
- An interrupt with mem_valid=0 is not taken until a valid instruction reaches MEM.
- Simultaneous flags: only the highest-priority one is committed.
- Simultaneous interrupt and ERET: INT wins, redirect to EXC_VECTOR.
- Reset asserted mid-sequence returns to IDLE immediately: flush and strobes drop, no partial cp0_en.

Test Plan:
- Reset mid-FLUSH -> flush, cp0_en and redirect_valid drop to 0 asynchronously; the next request after release behaves normally.
- exc_sys=1, mem_pc=32'hBFC0_1000, mem_in_delayslot=0, stallW=0 -> T+1: cp0_en=1 for exactly 1 cycle, except_type=`EXC_TYPE_SYS, exc_pc=32'hBFC0_1000, exc_bd=0, redirect_pc=32'hBFC0_0380. flush is high for 2 cycles, then busy=0.
- exc_ri=1 and exc_ov=1 together, exc_adel_d=1, mem_addr=32'h8000_0003 -> except_type=`EXC_TYPE_RI, badvaddr=0. In a separate test, only exc_ades=1 -> `EXC_TYPE_ADES, badvaddr=32'h8000_0003.
- is_eret=1, epc_i=32'h1111_0000, wb_mtc0_we=1 to EPC with data 32'h2222_0000 -> except_type=`EXC_TYPE_ERET, redirect_pc=32'h2222_0000. The same case with wb_mtc0_we=0 -> redirect_pc=32'h1111_0000.
- status_i=32'h0000_0401, cause_i=32'h0000_0400, mem_valid=1, is_eret=1 -> `EXC_TYPE_INT, redirect_pc=EXC_VECTOR. With status_i[1]=1 (EXL set) -> no INT taken; ERET is committed instead.
- exc_bp held with stallW=1 for 3 cycles -> cp0_en=0 throughout. stallW falls -> cp0_en is asserted one cycle later; a second exc_bp during FLUSH produces no second cp0_en.
